sram_ctrl_be: RTL and testbench
===============================

Name: sram_ctrl_be

Overview:
Parametrised single-port synchronous SRAM with a valid/ready request interface, per-byte write enables, a configurable read pipeline (1 or 2 cycles) and a hardware clear engine that zero-fills the array. It is the next generation of the plain clk/we/addr/data_in/data_out SRAM top. It adds variable width and depth, byte masking, range checking and deterministic memory contents after reset. It sits between bus-side masters and on-chip storage.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 10, address width.
DEPTH, 1024, number of words; 1 <= DEPTH <= 2**ADDR_W.
RD_LAT, 1, read latency in cycles from request acceptance to rsp_valid; legal values 1 or 2.
CLEAR_ON_RESET, 1, 1 = run the zero-fill automatically after reset release.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted this cycle when req_valid && req_ready.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  word address.
req_wdata  in  DATA_W  write data.
req_be  in  DATA_W/8  byte enables; bit i covers req_wdata[8i+7:8i].
rsp_valid  out  1  read data valid; single-cycle pulse per accepted read.
rsp_rdata  out  DATA_W  read data.
rsp_err  out  1  qualifies rsp_valid; 1 = address >= DEPTH.
clear_start  in  1  request a zero-fill of the whole array.
busy  out  1  clear engine running.
init_done  out  1  sticky; set at the end of the first completed clear.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, init_done=0. The read pipeline and FSM state are reset; the array contents are not.
- FSM states: RESET_WAIT, CLEAR, IDLE.
  - While rst is high the FSM is held in RESET_WAIT.
  - On the first clk after rst deasserts: go to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
- CLEAR:
  - Clear counter starts at 0 and writes all-zero data to one word per cycle.
  - Returns to IDLE after writing word DEPTH-1, so CLEAR takes exactly DEPTH cycles.
  - busy=1 and req_ready=0 throughout CLEAR.
  - On exit, init_done goes to 1 and stays 1 until rst.
  - clear_start is ignored while in CLEAR.
- IDLE:
  - req_ready = !clear_start (combinational).
  - clear_start=1 goes to CLEAR next cycle. clear_start has priority over a simultaneous req_valid; that request is not accepted.
- Write (accepted, req_we=1):
  - Only bytes with req_be[i]=1 are updated at that clock edge.
  - req_be=0 is a legal no-op.
  - addr >= DEPTH: write is dropped and no response is generated.
  - Writes never produce rsp_valid.
- Read (accepted, req_we=0):
  - rsp_valid pulses exactly RD_LAT cycles after the accept edge.
  - rsp_rdata = word contents as of after all writes accepted on earlier cycles. A read accepted the cycle after a write to the same address returns the new data.
  - addr >= DEPTH: rsp_valid still fires with rsp_err=1 and rsp_rdata=0.
- Throughput: one request per cycle in IDLE. Back-to-back reads produce back-to-back responses in order.
- No response backpressure: the consumer must always accept rsp_valid.
- rsp_rdata holds its last value when rsp_valid=0; rsp_err is 0 whenever rsp_valid=0.
- Reads already in the pipeline when CLEAR begins complete normally with pre-clear data.
- Reset mid-clear:
  - Outputs return to reset values and init_done returns to 0.
  - After release the clear restarts from address 0 (if CLEAR_ON_RESET=1).
  - In-flight read responses are discarded.
- Width rules:
  - Clear counter is ADDR_W+1 bits so DEPTH = 2**ADDR_W terminates without wrap.
  - Range compare uses ADDR_W+1 bits.

Decomposition:
- Package sram_ctrl_pkg: FSM state enum (RESET_WAIT, CLEAR, IDLE), the legal RD_LAT values, and helper constant BE_W = DATA_W/8.
- One sub-module, sram_ctrl_rdpipe: an RD_LAT-deep valid/data/err shift pipeline with async reset of the valid bits.
- The array, FSM and clear counter stay in the top.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=1024 -> busy=1 for exactly 1024 cycles, req_ready=0 meanwhile, then init_done=1. A read of addr 5 then returns 0x00000000.
- Write 0xA5A5A5A5 to addr 5 with be=4'hF, then write 0x3C3C3C3C to addr 5 with be=4'b0101 -> read of addr 5 returns 0xA53CA53C after RD_LAT cycles (RD_LAT=1 and RD_LAT=2 builds).
- Write 0x11223344 to addr 10 on cycle N, read addr 10 on cycle N+1, and read addrs 10, 5, 10 back-to-back -> first read returns 0x11223344. The back-to-back reads give three consecutive rsp_valid pulses with data in request order.
- DEPTH=1000, ADDR_W=10: write 0xDEADBEEF to addr 1000, then read addr 1000 -> rsp_valid=1, rsp_err=1, rsp_rdata=0. Addr 999 is unaffected.
- clear_start and req_valid(write 0xFF to addr 3) in the same IDLE cycle -> req_ready=0 that cycle, write not performed, busy rises next cycle. A read issued one cycle before clear_start still returns its pre-clear value.
- Assert rst for 2 cycles at clear count 500 -> all outputs at reset values, init_done=0. After release, busy stays high for a full 1024 cycles before init_done=1.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared types and constants for the byte-enable SRAM controller:
//   - state_t      : controller FSM states
//   - RD_LAT_MIN/MAX : supported read pipeline depths
//   - be_w()       : number of byte lanes for a given data width
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    CLEAR      = 2'd1,
    IDLE       = 2'd2
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_ctrl_rdpipe.sv
// sram_ctrl_rdpipe
// RD_LAT-deep shift pipeline carrying read valid, data and error flag from the
// accept edge to the response outputs.
// Ports:
//   clk, rst               : clock, async active-high reset (clears all stages)
//   in_valid/in_data/in_err : read captured at the accept edge
//   out_valid/out_data/out_err : response; out_data holds when no valid arrives,
//                               out_err is only ever set alongside out_valid
module sram_ctrl_rdpipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] err;
  logic [DATA_W-1:0] dat [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld[0] <= 1'b0;
      err[0] <= 1'b0;
      dat[0] <= '0;
    end else begin
      vld[0] <= in_valid;
      err[0] <= in_valid & in_err;
      // Data only moves with a valid so the last response stays on the outputs.
      if (in_valid) dat[0] <= in_data;
    end
  end

  for (genvar g = 1; g < RD_LAT; g++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld[g] <= 1'b0;
        err[g] <= 1'b0;
        dat[g] <= '0;
      end else begin
        vld[g] <= vld[g-1];
        err[g] <= vld[g-1] & err[g-1];
        if (vld[g-1]) dat[g] <= dat[g-1];
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_err   = err[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/sram_ctrl_be.sv
// sram_ctrl_be
// Single-port synchronous SRAM with valid/ready requests, per-byte write
// enables, a 1- or 2-cycle read pipeline and a zero-fill clear engine.
// Ports:
//   clk, rst      : clock, async active-high reset
//   req_valid/req_ready : request handshake (accept when both high)
//   req_we        : 1 = write, 0 = read
//   req_addr      : word address (>= DEPTH is out of range)
//   req_wdata/req_be : write data and byte enables
//   rsp_valid/rsp_rdata/rsp_err : read response, err flags out-of-range reads
//   clear_start   : start a zero-fill of the whole array (from IDLE)
//   busy          : clear engine running
//   init_done     : sticky, set when the first clear completes
module sram_ctrl_be
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [DATA_W/8-1:0]     req_be,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  input  logic                    clear_start,
  output logic                    busy,
  output logic                    init_done
);

  localparam int BE_W = be_w(DATA_W);
  // Only 1 and 2 are supported; anything else is pulled to the nearest one.
  localparam int RD_LAT_EFF = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
  // One extra bit so DEPTH == 2**ADDR_W is representable in compares.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  state_t state, state_nxt;
  logic [ADDR_W:0] clr_cnt;
  logic            clr_last;
  logic            in_range;
  logic            accept;
  logic            wr_en;
  logic            rd_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  // State table:
  //   RESET_WAIT | held during reset, leaves on first clock after release
  //   CLEAR      | zero-fill one word per cycle, requests blocked
  //   IDLE       | serving requests, clear_start takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET_WAIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR && !clr_last) clr_cnt <= clr_cnt + 1'b1;
      else                             clr_cnt <= '0;
      if (clr_last) init_done <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    clr_last  = 1'b0;
    case (state)
      RESET_WAIT: state_nxt = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      CLEAR: begin
        busy = 1'b1;
        if (clr_cnt == LAST_C) begin
          clr_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        req_ready = !clear_start;
        if (clear_start) state_nxt = CLEAR;
      end
      default: state_nxt = RESET_WAIT;
    endcase
  end

  assign in_range = {1'b0, req_addr} < DEPTH_C;
  assign accept   = req_valid && req_ready;
  assign wr_en    = accept && req_we && in_range;
  assign rd_en    = accept && !req_we;

  // Array has no reset; deterministic contents come from the clear engine.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt[ADDR_W-1:0]] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Sampled into the first pipeline stage at the accept edge, so it reflects
  // every write committed on earlier edges and none of any later clear.
  assign rd_word = in_range ? mem[req_addr] : '0;

  sram_ctrl_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT_EFF)
  ) u_rdpipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_data   (rd_word),
    .in_err    (!in_range),
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata),
    .out_err   (rsp_err)
  );

endmodule

// File: tb/tb_sram_ctrl_be.sv
module tb_sram_ctrl_be;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1000;
  localparam int RD_LAT = 2;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [BE_W-1:0]   req_be = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              clear_start = 1'b0;
  logic              busy;
  logic              init_done;

  sram_ctrl_be #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RD_LAT(RD_LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .clear_start(clear_start), .busy(busy), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
    int                due;
  } exp_t;

  exp_t sb[$];
  logic [DATA_W-1:0] model [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.data);
          check("rsp_err", rsp_err, e.err);
          check("rsp_latency", cyc, e.due);
        end
      end else begin
        check("rsp_err_idle", rsp_err, 64'd0);
      end
    end
  end

  // One request cycle. Must only be called while the DUT is known to be IDLE.
  task automatic drive(input logic v, input logic we, input int addr,
                       input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be,
                       input logic cs);
    exp_t e;
    logic acc;
    req_valid   = v;
    req_we      = we;
    req_addr    = addr[ADDR_W-1:0];
    req_wdata   = wd;
    req_be      = be;
    clear_start = cs;
    @(negedge clk);
    if (v) check("req_ready", req_ready, {63'd0, !cs});
    acc = v && !cs;
    if (acc && !we) begin
      e.data = (addr < DEPTH) ? model[addr] : '0;
      e.err  = (addr >= DEPTH);
      e.due  = cyc + RD_LAT;
      sb.push_back(e);
    end
    if (acc && we && addr < DEPTH)
      for (int i = 0; i < BE_W; i++)
        if (be[i]) model[addr][8*i +: 8] = wd[8*i +: 8];
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    clear_start = 1'b0;
  endtask

  task automatic rd(input int addr);
    drive(1'b1, 1'b0, addr, '0, '0, 1'b0);
  endtask

  task automatic wr(input int addr, input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
    drive(1'b1, 1'b1, addr, wd, be, 1'b0);
  endtask

  // Counts busy cycles of one clear; bounded so a stuck DUT still finishes.
  task automatic wait_clear(output int n, output logic first_busy, output logic ready_seen);
    n = 0;
    ready_seen = 1'b0;
    first_busy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 0) first_busy = busy;
      if (busy) begin
        n++;
        if (req_ready) ready_seen = 1'b1;
      end else if (n > 0 || init_done) begin
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 64'd0);
    check({tag, "_rsp_valid"}, rsp_valid, 64'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    check({tag, "_rsp_err"},   rsp_err,   64'd0);
    check({tag, "_busy"},      busy,      64'd0);
    check({tag, "_init_done"}, init_done, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic fb, rs;
    int cnt;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst = 1'b0;

    wait_clear(n, fb, rs);
    check("clear_cycles", n, DEPTH);
    check("ready_during_clear", rs, 64'd0);
    check("init_done_after_clear", init_done, 64'd1);
    model_zero();

    rd(5);
    wr(5, 32'hA5A5A5A5, 4'hF);
    wr(5, 32'h3C3C3C3C, 4'b0101);
    rd(5);

    wr(10, 32'h11223344, 4'hF);
    rd(10);
    rd(10);
    rd(5);
    rd(10);

    wr(1000, 32'hDEADBEEF, 4'hF);
    rd(1000);
    rd(999);
    wr(7, 32'h12345678, 4'h0);
    rd(7);

    // Read just before a clear must return pre-clear data.
    rd(10);
    drive(1'b1, 1'b1, 3, 32'h000000FF, 4'hF, 1'b1);
    wait_clear(n, fb, rs);
    check("busy_rise_after_clear_start", fb, 64'd1);
    check("clear2_cycles", n, DEPTH);
    check("ready_during_clear2", rs, 64'd0);
    model_zero();
    rd(3);
    rd(10);

    for (int k = 0; k < 400; k++) begin
      logic v, we;
      int a;
      v  = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) a = $urandom_range(DEPTH, (1 << ADDR_W) - 1);
      else if ($urandom_range(0, 3) == 0) a = $urandom_range(0, DEPTH - 1);
      else a = $urandom_range(DEPTH - 8, DEPTH - 1) - 8 * $urandom_range(0, 1) * (DEPTH - 16) / 8;
      drive(v, we, a, $urandom, BE_W'($urandom), 1'b0);
    end
    repeat (RD_LAT + 2) drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    check("sb_drained", sb.size(), 64'd0);

    // Reset with a read in flight: its response must be discarded.
    rd(7);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("rst1");
    @(posedge clk);
    #1;
    rst = 1'b0;

    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (cnt == 500) break;
    end
    check("mid_clear_reached", cnt, 64'd500);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst2");
    @(posedge clk);
    #1;
    rst = 1'b0;

    wait_clear(n, fb, rs);
    check("restart_clear_cycles", n, DEPTH);
    check("init_done_after_restart", init_done, 64'd1);
    model_zero();
    rd(7);
    rd(DEPTH - 1);
    rd(DEPTH);
    repeat (RD_LAT + 2) drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    check("sb_drained_end", sb.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
